// File: rtl/uncached_bus_ctrl_if.sv
`timescale 1ns/1ps
// uncached_bus_ctrl_if
// Bundles the pipeline-side uncached data/instruction request ports and the
// single uncached memory port.
//   slave  : the controller (consumes d_*/i_* requests, drives mem_* commands)
//   master : the surroundings (pipeline masters plus memory/bridge model)
interface uncached_bus_ctrl_if;
  // Data side
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wrdata;
  logic [3:0]  d_be;
  logic        d_stall;
  logic [31:0] d_rddata;
  // Instruction side
  logic        i_read;
  logic [31:0] i_addr;
  logic        i_stall;
  logic [31:0] i_rddata;
  logic        wb_empty;
  // Memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wrdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        mem_resp;
  logic [31:0] mem_rddata;

  modport slave (
    input  d_read, d_write, d_addr, d_wrdata, d_be, i_read, i_addr,
    input  mem_ready, mem_resp, mem_rddata,
    output d_stall, d_rddata, i_stall, i_rddata, wb_empty,
    output mem_req, mem_we, mem_addr, mem_wrdata, mem_be
  );

  modport master (
    output d_read, d_write, d_addr, d_wrdata, d_be, i_read, i_addr,
    output mem_ready, mem_resp, mem_rddata,
    input  d_stall, d_rddata, i_stall, i_rddata, wb_empty,
    input  mem_req, mem_we, mem_addr, mem_wrdata, mem_be
  );
endinterface

// File: rtl/uncached_bus_ctrl.sv
`timescale 1ns/1ps
// uncached_bus_ctrl
// Serialises all uncached traffic onto one memory port with a single
// outstanding transaction. Data stores are posted into a WB_DEPTH-entry
// write buffer; data reads wait until the buffer has drained so MMIO
// store->load order holds. Data side and instruction fetches share the port
// round-robin.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   io_bus : uncached_bus_ctrl_if.slave (d_*, i_*, wb_empty, mem_*)
module uncached_bus_ctrl #(
  parameter int unsigned WB_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  uncached_bus_ctrl_if.slave io_bus
);

  localparam int unsigned PtrW = $clog2(WB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count, w_count_next;
  logic [31:0]     r_wb_addr [WB_DEPTH];
  logic [31:0]     r_wb_data [WB_DEPTH];
  logic [3:0]      r_wb_be   [WB_DEPTH];

  logic            r_last_data;  // 1: data side won the previous grant
  logic            r_own_data;   // owner of the current transaction
  logic            r_cmd_we;
  logic [31:0]     r_cmd_addr;
  logic [31:0]     r_cmd_wrdata;
  logic [3:0]      r_cmd_be;
  logic [31:0]     r_rddata;

  logic            w_full, w_empty, w_push, w_pop;
  logic            w_d_cand, w_grant_d, w_latch;
  logic            w_cmd_we;
  logic [31:0]     w_cmd_addr, w_cmd_wrdata;
  logic [3:0]      w_cmd_be;
  logic            w_done_d, w_done_i;

  // Write buffer bookkeeping
  assign w_full  = (r_count == CntW'(WB_DEPTH));
  assign w_empty = (r_count == '0);
  // Refused when full even if the head retires this cycle.
  assign w_push  = io_bus.d_write & ~w_full;
  assign w_pop   = (r_state == StResp) & io_bus.mem_resp & r_cmd_we;
  assign w_count_next = r_count + CntW'(w_push) - CntW'(w_pop);

  // Arbitration only matters in StIdle, where no write can be in flight, so
  // a data read is eligible exactly when the buffer is empty.
  assign w_d_cand  = ~w_empty | io_bus.d_read;
  assign w_grant_d = w_d_cand & (~io_bus.i_read | ~r_last_data);

  always_comb begin
    w_cmd_we     = 1'b0;
    w_cmd_addr   = io_bus.i_addr;
    w_cmd_wrdata = '0;
    w_cmd_be     = 4'hF;
    if (w_grant_d) begin
      if (!w_empty) begin
        w_cmd_we     = 1'b1;
        w_cmd_addr   = r_wb_addr[r_rptr];
        w_cmd_wrdata = r_wb_data[r_rptr];
        w_cmd_be     = r_wb_be[r_rptr];
      end else begin
        w_cmd_addr   = io_bus.d_addr;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_d_cand || io_bus.i_read) begin
          w_latch      = 1'b1;
          w_state_next = StReq;
        end
      end
      StReq:  if (io_bus.mem_ready) w_state_next = StResp;
      StResp: if (io_bus.mem_resp) w_state_next = r_cmd_we ? StIdle : StDone;
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_last_data  <= 1'b0;
      r_own_data   <= 1'b0;
      r_cmd_we     <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_wrdata <= '0;
      r_cmd_be     <= '0;
      r_rddata     <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_latch) begin
        r_last_data  <= w_grant_d;
        r_own_data   <= w_grant_d;
        r_cmd_we     <= w_cmd_we;
        r_cmd_addr   <= w_cmd_addr;
        r_cmd_wrdata <= w_cmd_wrdata;
        r_cmd_be     <= w_cmd_be;
      end
      if ((r_state == StResp) && io_bus.mem_resp && !r_cmd_we) begin
        r_rddata <= io_bus.mem_rddata;
      end
    end
  end

  // Payload storage needs no reset; the count qualifies it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_wptr] <= io_bus.d_addr;
      r_wb_data[r_wptr] <= io_bus.d_wrdata;
      r_wb_be[r_wptr]   <= io_bus.d_be;
    end
  end

  assign w_done_d = (r_state == StDone) &  r_own_data;
  assign w_done_i = (r_state == StDone) & ~r_own_data;

  assign io_bus.d_stall  = io_bus.d_write ? w_full : (io_bus.d_read & ~w_done_d);
  assign io_bus.i_stall  = io_bus.i_read & ~w_done_i;
  assign io_bus.d_rddata = r_rddata;
  assign io_bus.i_rddata = r_rddata;
  assign io_bus.wb_empty = w_empty &
                           ~(((r_state == StReq) || (r_state == StResp)) & r_cmd_we);

  assign io_bus.mem_req    = (r_state == StReq);
  assign io_bus.mem_we     = r_cmd_we;
  assign io_bus.mem_addr   = r_cmd_addr;
  assign io_bus.mem_wrdata = r_cmd_wrdata;
  assign io_bus.mem_be     = r_cmd_be;

endmodule

// File: tb/tb_uncached_bus_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for uncached_bus_ctrl with a behavioural memory port
// and command/read-data scoreboards.
module tb_uncached_bus_ctrl;

  localparam int unsigned WbDepth = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } cmd_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;

  cmd_t        exp_q[$];
  cmd_t        obs_q[$];
  int          acc_cyc_q[$];
  int          resp_cyc_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] mem [logic [31:0]];

  bit ready_block;
  int ready_wait;
  int resp_delay;

  uncached_bus_ctrl_if bus ();

  uncached_bus_ctrl #(.WB_DEPTH(WbDepth)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded, got no finish, want finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  function automatic cmd_t mk_cmd(input logic we, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] be);
    cmd_t c;
    c.we = we; c.addr = a; c.data = d; c.be = be;
    return c;
  endfunction

  // Memory port model: accepts on mem_req & mem_ready, answers resp_delay
  // cycles later, applies writes with byte enables.
  initial begin : mem_model
    cmd_t        c;
    bit          acc, pend;
    int          wcnt, rcnt;
    logic [31:0] pdata, v;
    bus.mem_ready = 1'b0; bus.mem_resp = 1'b0; bus.mem_rddata = '0;
    pend = 0; wcnt = 0; rcnt = 0; pdata = '0; c = '0;
    forever begin
      @(negedge clk);
      acc = rst_n && bus.mem_req && bus.mem_ready;
      if (acc) c = mk_cmd(bus.mem_we, bus.mem_addr, bus.mem_wrdata, bus.mem_be);
      @(posedge clk);
      #1;
      bus.mem_resp = 1'b0;
      if (!rst_n) begin
        pend = 0; rcnt = 0; bus.mem_ready = 1'b0;
      end else begin
        if (acc) begin
          obs_q.push_back(c);
          acc_cyc_q.push_back(cyc - 1);
          if (c.we) begin
            v = mem_rd(c.addr);
            for (int i = 0; i < 4; i++) if (c.be[i]) v[8*i +: 8] = c.data[8*i +: 8];
            mem[c.addr] = v;
            pdata = 32'h0BAD_0BAD;
          end else begin
            pdata = mem_rd(c.addr);
          end
          pend = 1; wcnt = resp_delay;
        end
        if (pend) begin
          if (wcnt <= 1) begin
            bus.mem_resp = 1'b1; bus.mem_rddata = pdata;
            resp_cyc_q.push_back(cyc); pend = 0;
          end else begin
            wcnt--;
          end
        end
        if (bus.mem_req) begin
          bus.mem_ready = !ready_block && (rcnt >= ready_wait);
          rcnt++;
        end else begin
          bus.mem_ready = 1'b0; rcnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wrdata = '0;
    bus.d_be = '0; bus.i_read = 1'b0; bus.i_addr = '0;
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); acc_cyc_q.delete(); resp_cyc_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    ready_block = 0; ready_wait = 0; resp_delay = 1;
    step(); step();
    clear_sb();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    ready_block = 0; ready_wait = 0; resp_delay = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req);
    end
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wrdata, bus.mem_be} !== 69'd0) begin
      errors++;
      $display("FAIL reset_cmd: got we=%b addr=%h wd=%h be=%h want all 0",
               bus.mem_we, bus.mem_addr, bus.mem_wrdata, bus.mem_be);
    end
    checks++;
    if (bus.wb_empty !== 1'b1) begin
      errors++; $display("FAIL reset_wb_empty: got %b want 1", bus.wb_empty);
    end
    checks++;
    if ({bus.d_stall, bus.i_stall} !== 2'b00) begin
      errors++; $display("FAIL reset_stalls: got %b%b want 00", bus.d_stall, bus.i_stall);
    end
    checks++;
    if ({bus.d_rddata, bus.i_rddata} !== 64'd0) begin
      errors++; $display("FAIL reset_rddata: got %h/%h want 0/0", bus.d_rddata, bus.i_rddata);
    end
    step(); step();
    rst_n = 1'b1;
    step(); #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.wb_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got req=%b empty=%b want 0/1", bus.mem_req, bus.wb_empty);
    end
  endtask

  task automatic test_single_read();
    logic [31:0] a;
    a = 32'h1FD0_0000;
    mem[a] = 32'hDEAD_BEEF;
    step();
    bus.d_read = 1'b1; bus.d_addr = a;
    exp_q.push_back(mk_cmd(1'b0, a, 32'h0, 4'hF));
    exp_rd_q.push_back(32'hDEAD_BEEF);
    #1;
    checks++;
    if (bus.d_stall !== 1'b1) begin
      errors++; $display("FAIL rd_stall_c0: got %b want 1", bus.d_stall);
    end
    step(); #1;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF ||
        bus.mem_addr !== a) begin
      errors++;
      $display("FAIL rd_cmd_c1: got req=%b we=%b be=%h addr=%h want 1 0 f %h",
               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, a);
    end
    step(); #1;
    checks++;
    if (bus.d_stall !== 1'b1) begin
      errors++; $display("FAIL rd_stall_c2: got %b want 1", bus.d_stall);
    end
    step(); #1;
    checks++;
    if (bus.d_stall !== 1'b0) begin
      errors++; $display("FAIL rd_stall_c3: got %b want 0", bus.d_stall);
    end
    checks++;
    if (bus.d_rddata !== exp_rd_q[0]) begin
      errors++; $display("FAIL rd_data_c3: got %h want %h", bus.d_rddata, exp_rd_q[0]);
    end
    void'(exp_rd_q.pop_front());
    step();
    bus.d_read = 1'b0;
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL rd_cmd_log: got n=%0d first=%h want n=1 %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
    end
    clear_sb();
  endtask

  task automatic test_wb_fill();
    logic [31:0] a[5];
    logic [31:0] d[5];
    logic [3:0]  be[5];
    int          hold_bad, acc5, empty_cyc;
    bit          got;
    for (int i = 0; i < 5; i++) begin
      a[i]  = 32'h1FD0_0100 + 32'(4 * i);
      d[i]  = 32'hA000_0000 | 32'(i);
      be[i] = (i == 2) ? 4'b0011 : 4'hF;
    end
    ready_block = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.d_write = 1'b1; bus.d_addr = a[i]; bus.d_wrdata = d[i]; bus.d_be = be[i];
      #1;
      checks++;
      if (bus.d_stall !== 1'b0) begin
        errors++; $display("FAIL fill_accept_%0d: got stall=%b want 0", i, bus.d_stall);
      end
      exp_q.push_back(mk_cmd(1'b1, a[i], d[i], be[i]));
    end
    step();
    bus.d_addr = a[4]; bus.d_wrdata = d[4]; bus.d_be = be[4];
    #1;
    checks++;
    if (bus.d_stall !== 1'b1 || bus.wb_empty !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got stall=%b empty=%b want 1/0", bus.d_stall, bus.wb_empty);
    end
    hold_bad = 0;
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      if (bus.d_stall !== 1'b1) hold_bad++;
    end
    checks++;
    if (hold_bad != 0) begin
      errors++; $display("FAIL fill_stall_hold: got %0d unstalled cycles want 0", hold_bad);
    end
    ready_block = 0;
    got = 0; acc5 = 0;
    for (int k = 0; k < 50; k++) begin
      step(); #1;
      if (!bus.d_stall) begin got = 1; acc5 = cyc; break; end
    end
    checks++;
    if (!got || resp_cyc_q.size() == 0 || acc5 != resp_cyc_q[0] + 1) begin
      errors++;
      $display("FAIL fill_fifth_accept: got accepted=%0b cycle=%0d want cycle after first resp %0d",
               got, acc5, (resp_cyc_q.size() > 0) ? resp_cyc_q[0] : -1);
    end
    exp_q.push_back(mk_cmd(1'b1, a[4], d[4], be[4]));
    step();
    bus.d_write = 1'b0;
    got = 0; empty_cyc = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (bus.wb_empty) begin got = 1; empty_cyc = cyc; break; end
      step();
    end
    checks++;
    if (!got || resp_cyc_q.size() != 5 || empty_cyc != resp_cyc_q[4] + 1) begin
      errors++;
      $display("FAIL fill_wb_empty: got risen=%0b cycle=%0d resps=%0d want 5 resps, cycle %0d",
               got, empty_cyc, resp_cyc_q.size(),
               (resp_cyc_q.size() == 5) ? resp_cyc_q[4] + 1 : -1);
    end
    checks++;
    if (obs_q.size() != 5) begin
      errors++; $display("FAIL fill_drain_count: got %0d want 5", obs_q.size());
    end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL fill_drain_%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    clear_sb();
  endtask

  task automatic test_store_load();
    logic [31:0] a, x;
    bit          got;
    a = 32'h1FD0_0010; x = 32'h1234_5678;
    step();
    bus.d_write = 1'b1; bus.d_addr = a; bus.d_wrdata = x; bus.d_be = 4'hF;
    exp_q.push_back(mk_cmd(1'b1, a, x, 4'hF));
    #1;
    checks++;
    if (bus.d_stall !== 1'b0) begin
      errors++; $display("FAIL sl_write_accept: got stall=%b want 0", bus.d_stall);
    end
    step();
    bus.d_write = 1'b0; bus.d_read = 1'b1;
    exp_q.push_back(mk_cmd(1'b0, a, 32'h0, 4'hF));
    exp_rd_q.push_back(x);
    got = 0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (!bus.d_stall) begin got = 1; break; end
      step();
    end
    checks++;
    if (!got || bus.d_rddata !== exp_rd_q[0]) begin
      errors++;
      $display("FAIL sl_read_data: got done=%0b data=%h want %h", got, bus.d_rddata, exp_rd_q[0]);
    end
    void'(exp_rd_q.pop_front());
    step();
    bus.d_read = 1'b0;
    checks++;
    if (acc_cyc_q.size() != 2 || resp_cyc_q.size() < 1 || acc_cyc_q[1] <= resp_cyc_q[0]) begin
      errors++;
      $display("FAIL sl_order: got accepts=%0d read_accept=%0d want read accepted after resp %0d",
               acc_cyc_q.size(), (acc_cyc_q.size() > 1) ? acc_cyc_q[1] : -1,
               (resp_cyc_q.size() > 0) ? resp_cyc_q[0] : -1);
    end
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL sl_cmds: got n=%0d want n=2 {%h,%h}", obs_q.size(), exp_q[0], exp_q[1]);
    end
    clear_sb();
  endtask

  task automatic test_round_robin();
    logic [31:0] ia[3];
    logic [31:0] wa[3];
    logic [31:0] wd[3];
    int          ni, wr_rej;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ia[i] = 32'h1FC0_0000 + 32'(64 * i);
      wa[i] = 32'h1FD0_0200 + 32'(4 * i);
      wd[i] = 32'hB000_0000 | 32'(i);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk_cmd(1'b1, wa[i], wd[i], 4'hF));
      exp_q.push_back(mk_cmd(1'b0, ia[i], 32'h0, 4'hF));
    end
    ni = 0; wr_rej = 0;
    for (int t = 0; t < 200; t++) begin
      step();
      bus.d_write = (t < 3);
      if (t < 3) begin
        bus.d_addr = wa[t]; bus.d_wrdata = wd[t]; bus.d_be = 4'hF;
      end
      bus.i_read = (t >= 1) && (ni < 3);
      if (ni < 3) bus.i_addr = ia[ni];
      #1;
      if (t < 3 && bus.d_stall) wr_rej++;
      if (bus.i_read && !bus.i_stall) begin
        checks++;
        if (bus.i_rddata !== ~ia[ni]) begin
          errors++; $display("FAIL rr_idata_%0d: got %h want %h", ni, bus.i_rddata, ~ia[ni]);
        end
        ni++;
      end
      if (t >= 3 && ni == 3 && bus.wb_empty) break;
    end
    step();
    idle_inputs();
    checks++;
    if (ni != 3 || wr_rej != 0) begin
      errors++;
      $display("FAIL rr_progress: got fetches=%0d rejected_writes=%0d want 3/0", ni, wr_rej);
    end
    checks++;
    if (obs_q.size() != 6) begin
      errors++; $display("FAIL rr_count: got %0d want 6", obs_q.size());
    end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rr_order_%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    clear_sb();
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    cmd_t        first;
    int          c0, done_cyc, req_cycles, unstable;
    bit          got;
    a = 32'h1FD0_0020;
    mem[a] = 32'hCAFE_F00D;
    ready_wait = 5; resp_delay = 3;
    step();
    bus.d_read = 1'b1; bus.d_addr = a;
    exp_rd_q.push_back(32'hCAFE_F00D);
    c0 = cyc; req_cycles = 0; unstable = 0; got = 0; done_cyc = 0; first = '0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (bus.mem_req) begin
        if (req_cycles == 0)
          first = mk_cmd(bus.mem_we, bus.mem_addr, bus.mem_wrdata, bus.mem_be);
        else if (mk_cmd(bus.mem_we, bus.mem_addr, bus.mem_wrdata, bus.mem_be) !== first)
          unstable++;
        req_cycles++;
      end
      if (!bus.d_stall) begin got = 1; done_cyc = cyc; break; end
      step();
    end
    checks++;
    if (!got || done_cyc - c0 != 10) begin
      errors++;
      $display("FAIL bp_latency: got done=%0b latency=%0d want 10", got, done_cyc - c0);
    end
    checks++;
    if (req_cycles != 6 || unstable != 0) begin
      errors++;
      $display("FAIL bp_req_hold: got req_cycles=%0d changes=%0d want 6/0", req_cycles, unstable);
    end
    checks++;
    if (first.we !== 1'b0 || first.addr !== a || first.be !== 4'hF) begin
      errors++;
      $display("FAIL bp_cmd: got we=%b addr=%h be=%h want 0 %h f", first.we, first.addr,
               first.be, a);
    end
    checks++;
    if (resp_cyc_q.size() != 1 || acc_cyc_q.size() != 1 ||
        resp_cyc_q[0] - acc_cyc_q[0] != 3 || done_cyc != resp_cyc_q[0] + 1) begin
      errors++;
      $display("FAIL bp_done_after_resp: got done=%0d resp=%0d want done = resp+1", done_cyc,
               (resp_cyc_q.size() > 0) ? resp_cyc_q[0] : -1);
    end
    checks++;
    if (bus.d_rddata !== exp_rd_q[0]) begin
      errors++; $display("FAIL bp_data: got %h want %h", bus.d_rddata, exp_rd_q[0]);
    end
    void'(exp_rd_q.pop_front());
    step();
    bus.d_read = 1'b0;
    ready_wait = 0; resp_delay = 1;
    clear_sb();
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    int          c0, done_cyc;
    bit          got;
    resp_delay = 30;
    step();
    bus.d_write = 1'b1; bus.d_addr = 32'h1FD0_0300; bus.d_wrdata = 32'h1111_1111;
    bus.d_be = 4'hF;
    step();
    bus.d_addr = 32'h1FD0_0304; bus.d_wrdata = 32'h2222_2222;
    step();
    bus.d_write = 1'b0;
    step(); #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.wb_empty !== 1'b0 || obs_q.size() != 1) begin
      errors++;
      $display("FAIL rm_pre: got req=%b empty=%b accepts=%0d want 0/0/1", bus.mem_req,
               bus.wb_empty, obs_q.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.wb_empty !== 1'b1 || bus.mem_we !== 1'b0 ||
        bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rm_in_reset: got req=%b empty=%b we=%b addr=%h want 0 1 0 0",
               bus.mem_req, bus.wb_empty, bus.mem_we, bus.mem_addr);
    end
    checks++;
    if ({bus.d_stall, bus.i_stall} !== 2'b00) begin
      errors++; $display("FAIL rm_stalls: got %b%b want 00", bus.d_stall, bus.i_stall);
    end
    step(); step();
    clear_sb();
    resp_delay = 1;
    rst_n = 1'b1;
    a = 32'h1FD0_0030;
    mem[a] = 32'h5A5A_1234;
    step();
    bus.d_read = 1'b1; bus.d_addr = a;
    exp_q.push_back(mk_cmd(1'b0, a, 32'h0, 4'hF));
    exp_rd_q.push_back(32'h5A5A_1234);
    c0 = cyc; got = 0; done_cyc = 0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (!bus.d_stall) begin got = 1; done_cyc = cyc; break; end
      step();
    end
    checks++;
    if (!got || done_cyc - c0 != 3 || bus.d_rddata !== exp_rd_q[0]) begin
      errors++;
      $display("FAIL rm_fresh_read: got done=%0b latency=%0d data=%h want 3 %h", got,
               done_cyc - c0, bus.d_rddata, exp_rd_q[0]);
    end
    void'(exp_rd_q.pop_front());
    step();
    bus.d_read = 1'b0;
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL rm_cmds: got n=%0d want n=1 %h", obs_q.size(), exp_q[0]);
    end
    clear_sb();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_read();
    test_wb_fill();
    test_store_load();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uncached_bus_ctrl.md
# uncached_bus_ctrl

Sequences all uncached memory traffic onto the single uncached memory port. It holds a posted write buffer for uncached data stores and arbitrates round-robin between the data side (buffered writes and data reads) and uncached instruction fetches. Only one transaction is outstanding on the port at a time. It sits between the `dbus_uncached` / `ibus_uncached` master interfaces of the pipeline and the bus bridge.

## Interface
- `WB_DEPTH`, 4: posted write buffer entries; power of two, at least 2.
- `clk` input 1: the single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `d_read` input 1: uncached data read request; held until the cycle `d_stall`=0.
- `d_write` input 1: uncached data write request; never asserted together with `d_read`.
- `d_addr` input 32: data request address; bits [1:0] are zero.
- `d_wrdata` input 32: store data.
- `d_be` input 4: data byte enables.
- `d_stall` output 1: data request not yet complete.
- `d_rddata` output 32: data read result; valid in the cycle where `d_read`=1 and `d_stall`=0.
- `i_read` input 1: uncached instruction read request; held until the cycle `i_stall`=0.
- `i_addr` input 32: instruction read address.
- `i_stall` output 1: instruction request not yet complete.
- `i_rddata` output 32: instruction read result; valid in the cycle where `i_read`=1 and `i_stall`=0.
- `wb_empty` output 1: write buffer empty and no write in flight; used by SYNC.
- `mem_req` output 1: address/command valid toward the memory port.
- `mem_we` output 1: 1 = write, 0 = read.
- `mem_addr` output 32: memory port address.
- `mem_wrdata` output 32: memory port write data.
- `mem_be` output 4: memory port byte enables; 4'hF for reads.
- `mem_ready` input 1: command accepted when `mem_req` & `mem_ready`.
- `mem_resp` input 1: one-cycle response pulse; one pulse per accepted command.
- `mem_rddata` input 32: read data, valid together with `mem_resp`.

## Operation
- **Write buffer**
  - Circular FIFO of {addr, wrdata, be}.
  - Push when `d_write` & ~full. `d_stall` = full for writes, a combinational function of the registered count.
  - No push-through when full: a push is refused even if a pop occurs in the same cycle.
  - Pop (head retired) on `mem_resp` of a buffered write.
  - The count is (WB_DEPTH+1)-state. Pointers wrap modulo WB_DEPTH.
- **Ordering**
  - A data read is eligible only when the buffer is empty and no write is in flight. This preserves MMIO store→load order.
  - A data read never bypasses the write buffer. Instruction reads may bypass it.
- **Arbitration**
  - Performed only in IDLE.
  - Data-side candidate: buffer head if the buffer is non-empty; else the data read if eligible.
  - Instruction candidate: `i_read`.
  - If both candidates are present, round-robin: the side not granted last wins. The `last` flag resets to instruction, so data wins the first tie.
  - The winner's command is latched into command registers.
- **FSM states**
  - IDLE: no candidate → stay in IDLE. Otherwise latch the winner → REQ.
  - REQ: `mem_req`=1 with the latched command; `mem_ready` → RESP.
  - RESP: wait for `mem_resp`.
    - Write: pop the buffer → IDLE.
    - Read: capture `mem_rddata` into the read register → DONE.
  - DONE: deassert the owner's stall for exactly one cycle, drive its rddata from the register → IDLE.
- **Stall outputs**
  - `d_stall` for reads = ~(state==DONE & owner==data). `d_stall` for writes = full.
  - `i_stall` = `i_read` & ~(state==DONE & owner==instr).
  - Stalls are 0 when no request is present.
- **Other behaviour**
  - `wb_empty` = count==0 & ~(state∈{REQ,RESP} & owner is a write).
  - A `mem_resp` outside RESP is ignored.
  - Command fields are stable for the whole of REQ.
- **Reset**
  - Asynchronous reset clears the FSM to IDLE, count and pointers to 0, and `last`=instr.
  - Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wrdata`=0, `mem_be`=0, rd registers 0, `wb_empty`=1.
  - Reset mid-transaction abandons it. The memory side is reset by the same `rst_n`.

## Timing
- Write push: zero-latency accept. `d_write` with not-full → `d_stall`=0 in the same cycle, and the entry is visible next cycle.
- Read, zero-wait memory (`mem_ready` in the first REQ cycle, `mem_resp` one cycle after accept):
  - request at cycle c0 (IDLE);
  - REQ at c1;
  - RESP at c2, with `mem_resp` at c2;
  - DONE at c3, where stall=0 and rddata is valid.
  - Minimum read latency is 3 cycles.
- Each extra `mem_ready` wait cycle or `mem_resp` delay cycle adds one cycle.
- Write drain: minimum 3 cycles per entry (IDLE, REQ, RESP).
- A requester must not drop or alter a read while its stall is 1. Dropping before the grant is legal.

## Test plan
- **Single data read, zero-wait memory.** `d_read` at 0x1FD0_0000 with `mem_rddata`=0xDEAD_BEEF → `mem_req` on cycle c1 with `mem_we`=0, `mem_be`=4'hF; `d_stall` falls on c3 with `d_rddata`=0xDEAD_BEEF.
- **Write buffer fill and drain.** Five back-to-back writes with WB_DEPTH=4 and `mem_ready` held low → the first four accept in 4 cycles and the fifth stalls until the first `mem_resp`. Drain order is addresses A0..A4, and `wb_empty` rises after the fifth `mem_resp`.
- **Store→load ordering.** Write X to 0x1FD0_0010, then `d_read` of 0x1FD0_0010 → the read command issues only after the write's `mem_resp`, and the memory model returns X.
- **Round-robin.** `i_read` and a buffered write both pending from reset → write granted first, instruction second. Repeated simultaneous traffic alternates data and instruction grants.
- **Backpressure.** `mem_ready` low for 5 cycles, then `mem_resp` delayed 3 cycles → `mem_req` and its fields stay constant during the wait, the owner's stall stays 1 throughout, and DONE occurs exactly one cycle after `mem_resp`.
- **Reset mid-transaction.** `rst_n` low while in RESP with 2 buffered entries → immediately `mem_req`=0, `wb_empty`=1, and both stalls are 0 for absent requests. After release, a fresh read completes normally.
